main_mem_arbiter: RTL and testbench

Shares the single main-memory request/response port between the instruction cache (read-only block refills) and the data cache (block refills and write-throughs). The arbiter sits between `_core` and `_main_mem` inside `top`. It grants one request per cycle using round-robin priority. It records the owner of every outstanding read in an in-order tag FIFO and routes each memory response back to its owner one cycle later through registered outputs.

---
 rtl/main_mem_arbiter.sv | 108 ++++++++++
 tb/tb_main_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between icache and dcache.
// An in-order owner-tag FIFO steers each read response back to its requester.
`ifndef MAIN_MEM_BLOCK_ADDR_WIDTH
`define MAIN_MEM_BLOCK_ADDR_WIDTH 32
`endif
`ifndef MAIN_MEM_BLOCK_DATA_WIDTH
`define MAIN_MEM_BLOCK_DATA_WIDTH 64
`endif

module main_mem_arbiter #(
  parameter int MAX_INFLIGHT     = 4,
  parameter int BLOCK_ADDR_WIDTH = `MAIN_MEM_BLOCK_ADDR_WIDTH,
  parameter int BLOCK_DATA_WIDTH = `MAIN_MEM_BLOCK_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ic_req_valid,
  input  logic [BLOCK_ADDR_WIDTH-1:0] ic_req_block_addr,
  output logic                        ic_req_ready,
  output logic                        ic_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] ic_resp_block_data,
  input  logic                        dc_req_valid,
  input  logic                        dc_req_type,
  input  logic [BLOCK_ADDR_WIDTH-1:0] dc_req_block_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] dc_req_block_data,
  output logic                        dc_req_ready,
  output logic                        dc_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0] dc_resp_block_data,
  output logic                        mem_req_valid,
  output logic                        mem_req_type,
  output logic [BLOCK_ADDR_WIDTH-1:0] mem_req_block_addr,
  output logic [BLOCK_DATA_WIDTH-1:0] mem_req_block_data,
  input  logic                        mem_req_ready,
  input  logic                        mem_resp_valid,
  input  logic [BLOCK_DATA_WIDTH-1:0] mem_resp_block_data,
  output logic                        err_unexpected_resp
);
  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MAX_INFLIGHT);

  logic [PTR_W-1:0]            wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]            count_reg, count_next;
  logic [MAX_INFLIGHT-1:0]     tag_reg;
  logic                        last_grant_reg;
  logic                        ic_resp_valid_reg, dc_resp_valid_reg;
  logic [BLOCK_DATA_WIDTH-1:0] ic_resp_data_reg, dc_resp_data_reg;
  logic                        err_reg;

  logic full, empty, ic_elig, dc_elig, grant_dc, accept, push, pop, head_owner;

  always_comb begin
    full       = (count_reg == DEPTH);
    empty      = (count_reg == '0);
    ic_elig    = ic_req_valid && !full;
    // Writes never occupy a tag slot, so a full FIFO cannot block them.
    dc_elig    = dc_req_valid && (dc_req_type || !full);
    grant_dc   = dc_elig && (!ic_elig || !last_grant_reg);
    mem_req_valid      = !rst && (ic_elig || dc_elig);
    mem_req_type       = grant_dc && dc_req_type;
    mem_req_block_addr = grant_dc ? dc_req_block_addr : ic_req_block_addr;
    mem_req_block_data = grant_dc ? dc_req_block_data : '0;
    accept       = mem_req_valid && mem_req_ready;
    ic_req_ready = accept && !grant_dc;
    dc_req_ready = accept && grant_dc;
    push       = accept && !mem_req_type;
    pop        = mem_resp_valid && !empty;
    head_owner = tag_reg[rd_ptr_reg];
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + 1'b1;
    else if (!push && pop) count_next = count_reg - 1'b1;
  end

  // Tag storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) tag_reg[wr_ptr_reg] <= grant_dc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
      last_grant_reg    <= 1'b1;
      ic_resp_valid_reg <= 1'b0;
      dc_resp_valid_reg <= 1'b0;
      ic_resp_data_reg  <= '0;
      dc_resp_data_reg  <= '0;
      err_reg           <= 1'b0;
    end else begin
      count_reg         <= count_next;
      ic_resp_valid_reg <= pop && !head_owner;
      dc_resp_valid_reg <= pop && head_owner;
      if (push)   wr_ptr_reg     <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg     <= rd_ptr_reg + 1'b1;
      if (accept) last_grant_reg <= grant_dc;
      if (pop && !head_owner) ic_resp_data_reg <= mem_resp_block_data;
      if (pop && head_owner)  dc_resp_data_reg <= mem_resp_block_data;
      if (mem_resp_valid && empty) err_reg <= 1'b1;
    end
  end

  assign ic_resp_valid       = ic_resp_valid_reg;
  assign dc_resp_valid       = dc_resp_valid_reg;
  assign ic_resp_block_data  = ic_resp_data_reg;
  assign dc_resp_block_data  = dc_resp_data_reg;
  assign err_unexpected_resp = err_reg;
endmodule

// File: tb/tb_main_mem_arbiter.sv
// Scoreboard bench for main_mem_arbiter: directed scenarios then random traffic
// checked against a queue-based reference of outstanding reads and grant priority.
module tb_main_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ic_req_valid = 1'b0, ic_req_ready, ic_resp_valid;
  logic [AW-1:0] ic_req_block_addr = '0;
  logic [DW-1:0] ic_resp_block_data;
  logic dc_req_valid = 1'b0, dc_req_type = 1'b0, dc_req_ready, dc_resp_valid;
  logic [AW-1:0] dc_req_block_addr = '0;
  logic [DW-1:0] dc_req_block_data = '0, dc_resp_block_data;
  logic mem_req_valid, mem_req_type, mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_block_addr;
  logic [DW-1:0] mem_req_block_data;
  logic mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_resp_block_data = '0;
  logic err_unexpected_resp;

  main_mem_arbiter #(.MAX_INFLIGHT(DEPTH), .BLOCK_ADDR_WIDTH(AW), .BLOCK_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_block_addr(ic_req_block_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_block_data(ic_resp_block_data),
    .dc_req_valid(dc_req_valid), .dc_req_type(dc_req_type), .dc_req_block_addr(dc_req_block_addr),
    .dc_req_block_data(dc_req_block_data), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_block_data(dc_resp_block_data),
    .mem_req_valid(mem_req_valid), .mem_req_type(mem_req_type), .mem_req_block_addr(mem_req_block_addr),
    .mem_req_block_data(mem_req_block_data), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_block_data(mem_resp_block_data),
    .err_unexpected_resp(err_unexpected_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          own;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  logic own_q[$];
  logic lg_m = 1'b1;
  logic err_m = 1'b0;
  logic ic_acc = 1'b0, dc_acc = 1'b0;
  int total = 0, bad = 0, cyc = 0;
  exp_t me;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: each expected response is due exactly one cycle after its mem_resp_valid.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      me = exp_q.pop_front();
      if (me.own) begin
        chk("dc_resp_valid", dc_resp_valid, 1);
        chk("ic_resp_idle", ic_resp_valid, 0);
        chk("dc_resp_data", dc_resp_block_data, me.data);
      end else begin
        chk("ic_resp_valid", ic_resp_valid, 1);
        chk("dc_resp_idle", dc_resp_valid, 0);
        chk("ic_resp_data", ic_resp_block_data, me.data);
      end
      $display("resp cyc=%0d owner=%s data=%h", cyc, me.own ? "dc" : "ic", me.data);
    end else begin
      chk("ic_resp_quiet", ic_resp_valid, 0);
      chk("dc_resp_quiet", dc_resp_valid, 0);
    end
  end

  // One cycle of stimulus; the reference decides grant from outstanding reads and last winner.
  task automatic step(input logic iv, input logic [AW-1:0] ia, input logic dv, input logic dt,
                      input logic [AW-1:0] da, input logic [DW-1:0] dd, input logic mr,
                      input logic rv, input logic [DW-1:0] rd);
    int n;
    logic full, e_ic, e_dc, ev, win, acc;
    exp_t e;
    @(posedge clk); #1;
    ic_req_valid = iv; ic_req_block_addr = ia;
    dc_req_valid = dv; dc_req_type = dt; dc_req_block_addr = da; dc_req_block_data = dd;
    mem_req_ready = mr; mem_resp_valid = rv; mem_resp_block_data = rd;
    @(negedge clk);
    n    = own_q.size();
    full = (n >= DEPTH);
    e_ic = iv && !full;
    e_dc = dv && (dt || !full);
    ev   = e_ic || e_dc;
    win  = (e_ic && e_dc) ? ~lg_m : e_dc;
    acc  = ev && mr;
    chk("mem_req_valid", mem_req_valid, ev);
    chk("ic_req_ready", ic_req_ready, acc && !win);
    chk("dc_req_ready", dc_req_ready, acc && win);
    chk("err_flag", err_unexpected_resp, err_m);
    if (ev) begin
      chk("mem_req_type", mem_req_type, win && dt);
      chk("mem_req_addr", mem_req_block_addr, win ? da : ia);
      if (win && dt) chk("mem_req_data", mem_req_block_data, dd);
    end
    if (acc) $display("req cyc=%0d grant=%s type=%0d addr=%h", cyc, win ? "dc" : "ic", win && dt, win ? da : ia);
    if (rv) begin
      if (n > 0) begin
        e.own = own_q.pop_front(); e.data = rd; e.due = cyc + 1;
        exp_q.push_back(e);
      end else begin
        err_m = 1'b1;
      end
    end
    if (acc) begin
      lg_m = win;
      if (!(win && dt)) own_q.push_back(win);
    end
    ic_acc = acc && !win;
    dc_acc = acc && win;
  endtask

  task automatic idle(input logic rv, input logic [DW-1:0] rd);
    step(0, '0, 0, 0, '0, '0, 0, rv, rd);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; ic_req_valid = 1'b1; dc_req_valid = 1'b1; dc_req_type = 1'b0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_ic_req_ready", ic_req_ready, 0);
    chk("rst_dc_req_ready", dc_req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0; ic_req_valid = 1'b0; dc_req_valid = 1'b0; mem_req_ready = 1'b0;
    own_q.delete(); exp_q.delete(); lg_m = 1'b1; err_m = 1'b0;
    @(negedge clk);
    chk("rst_ic_resp_valid", ic_resp_valid, 0);
    chk("rst_dc_resp_valid", dc_resp_valid, 0);
    chk("rst_ic_resp_data", ic_resp_block_data, 0);
    chk("rst_dc_resp_data", dc_resp_block_data, 0);
    chk("rst_err", err_unexpected_resp, 0);
  endtask

  logic r_iv, r_dv, r_dt, r_mr, r_rv;
  logic [AW-1:0] r_ia, r_da;
  logic [DW-1:0] r_dd;

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // icache-only read
    step(1, 32'h1018, 0, 0, '0, '0, 1, 0, '0);
    chk("t1_ic_ready", ic_req_ready, 1);
    chk("t1_addr", mem_req_block_addr, 32'h1018);
    idle(1, 64'hDEADBEEF_CAFEF00D);
    idle(0, '0);
    chk("t1_ic_data", ic_resp_block_data, 64'hDEADBEEF_CAFEF00D);
    idle(0, '0);

    // round-robin conflict right after reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h2000 + AW'(i), 1, 0, 32'h3000 + AW'(i >> 1), '0, 1, 0, '0);
      chk("rr_ic_first", ic_req_ready, (i % 2) == 0);
    end
    for (int i = 0; i < 4; i++) idle(1, 64'hA000 + DW'(i));
    idle(0, '0); idle(0, '0);

    // full FIFO blocks reads but not writes
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'h4000 + AW'(i), 0, 0, '0, '0, 1, 0, '0);
    step(1, 32'h4004, 1, 1, 32'h5000, 64'h55AA, 1, 0, '0);
    chk("full_ic_blocked", ic_req_ready, 0);
    chk("full_dc_write", dc_req_ready, 1);
    chk("full_wr_type", mem_req_type, 1);
    step(1, 32'h4004, 0, 0, '0, '0, 1, 1, 64'hB000);
    chk("full_no_bypass", ic_req_ready, 0);
    step(1, 32'h4004, 0, 0, '0, '0, 1, 0, '0);
    chk("full_then_accept", ic_req_ready, 1);
    for (int i = 0; i < 4; i++) idle(1, 64'hB100 + DW'(i));
    idle(0, '0); idle(0, '0);

    // simultaneous push/pop across pointer wrap
    do_reset();
    for (int i = 0; i < 6; i++)
      step((i % 2) == 0, 32'h6000 + AW'(i), (i % 2) == 1, 0, 32'h7000 + AW'(i), '0, 1, i > 0, 64'hC000 + DW'(i));
    idle(1, 64'hC0FF);
    idle(0, '0); idle(0, '0);

    // unexpected response with empty FIFO
    idle(1, 64'hBAD);
    idle(0, '0);
    chk("unexp_err_set", err_unexpected_resp, 1);
    idle(0, '0);
    chk("unexp_err_held", err_unexpected_resp, 1);
    do_reset();

    // reset with reads in flight
    step(1, 32'h8000, 0, 0, '0, '0, 1, 0, '0);
    step(0, '0, 1, 0, 32'h8100, '0, 1, 0, '0);
    do_reset();
    step(1, 32'h8200, 1, 0, 32'h8300, '0, 1, 0, '0);
    chk("post_rst_ic_wins", ic_req_ready, 1);
    idle(1, 64'hD000);
    idle(0, '0); idle(0, '0);
    do_reset();

    // randomized traffic; requests hold stable until accepted
    r_iv = 0; r_dv = 0; r_dt = 0; r_ia = '0; r_da = '0; r_dd = '0;
    for (int k = 0; k < 3000; k++) begin
      if (!(r_iv && !ic_acc)) begin
        r_iv = ($urandom_range(0, 99) < 60);
        r_ia = AW'($urandom);
      end
      if (!(r_dv && !dc_acc)) begin
        r_dv = ($urandom_range(0, 99) < 60);
        r_dt = ($urandom_range(0, 99) < 30);
        r_da = AW'($urandom);
        r_dd = {$urandom, $urandom};
      end
      r_mr = ($urandom_range(0, 99) < 75);
      r_rv = (own_q.size() > 0) && ($urandom_range(0, 99) < 45);
      step(r_iv, r_ia, r_dv, r_dt, r_da, r_dd, r_mr, r_rv, {$urandom, $urandom});
    end
    for (int k = 0; k < 2 * DEPTH && own_q.size() > 0; k++) idle(1, {$urandom, $urandom});
    idle(0, '0); idle(0, '0);
    chk("scoreboard_drained", DW'(exp_q.size()), 0);
    chk("tags_drained", DW'(own_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
